// File: rtl/decode_stage_if.sv
// Handshake and result bus for the RV32I decode/register-read stage.
// The master side feeds instructions, write-backs and the downstream ready;
// the slave side is the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic [6:0]      opcode_t2;
    logic [11:0]     immediate;
    logic [2:0]      function3;
    logic [6:0]      function7;
    logic [4:0]      rd;
    logic            illegal;

    modport master (
        output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, operand_1, operand_2, opcode_t2,
               immediate, function3, function7, rd, illegal
    );

    modport slave (
        input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, operand_1, operand_2, opcode_t2,
               immediate, function3, function7, rd, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode and register-read stage with a one-entry output register.
// Holds the 32x32 register file; write-back bypasses into the read path and
// refreshes a stalled output.
// Optional macro DECODE_REGFILE_CLEAR_EN: when defined, registers x1..x31
// clear under rst_n; otherwise the array has no reset and maps to RAM.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_R_ALU = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;

    logic [XLEN-1:0] regs [0:NREGS-1];

    logic            accept;
    logic            stall;
    logic            wb_hit;
    logic [6:0]      dec_opcode;
    logic            dec_r_type;
    logic            dec_i_type;
    logic            dec_legal;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Indices and type of the held instruction, used to refresh it while stalled.
    logic [4:0]      rs1_held;
    logic [4:0]      rs2_held;
    logic            r_type_held;
    logic            legal_held;

    // x0 reads zero; a same-cycle write to the index is forwarded.
    function automatic logic [XLEN-1:0] read_reg(
        input logic [4:0]      idx,
        input logic            wen,
        input logic [4:0]      widx,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        if (idx == 5'd0)
            return '0;
        else if (wen && (widx == idx))
            return wdata;
        else
            return stored;
    endfunction

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign wb_hit       = bus.wb_en && (bus.wb_rd != 5'd0);

    // Decode fields and register reads for the incoming instruction.
    always_comb begin
        dec_opcode = bus.in_instr[6:0];
        dec_r_type = (dec_opcode == OP_R_ALU);
        dec_i_type = (dec_opcode == OP_I_ALU);
        dec_legal  = dec_r_type || dec_i_type;
        dec_rs1    = bus.in_instr[19:15];
        dec_rs2    = bus.in_instr[24:20];
        rs1_val    = read_reg(dec_rs1, bus.wb_en, bus.wb_rd, bus.wb_data, regs[dec_rs1]);
        rs2_val    = read_reg(dec_rs2, bus.wb_en, bus.wb_rd, bus.wb_data, regs[dec_rs2]);
    end

`ifdef DECODE_REGFILE_CLEAR_EN
    // Register file write with x1..x31 cleared under reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end
`else
    // Register file write; no reset so the array maps to RAM. A write
    // presented while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wb_hit)
            regs[bus.wb_rd] <= bus.wb_data;
    end
`endif

    // Output register: load on accept, clear on consume, refresh while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.operand_1 <= '0;
            bus.operand_2 <= '0;
            bus.opcode_t2 <= '0;
            bus.immediate <= '0;
            bus.function3 <= '0;
            bus.function7 <= '0;
            bus.rd        <= '0;
            bus.illegal   <= 1'b0;
            rs1_held      <= '0;
            rs2_held      <= '0;
            r_type_held   <= 1'b0;
            legal_held    <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.operand_1 <= dec_legal  ? rs1_val : '0;
            bus.operand_2 <= dec_r_type ? rs2_val : '0;
            bus.opcode_t2 <= dec_opcode;
            bus.immediate <= dec_i_type ? bus.in_instr[31:20] : '0;
            bus.function3 <= bus.in_instr[14:12];
            bus.function7 <= bus.in_instr[31:25];
            bus.rd        <= bus.in_instr[11:7];
            bus.illegal   <= !dec_legal;
            rs1_held      <= dec_rs1;
            rs2_held      <= dec_rs2;
            r_type_held   <= dec_r_type;
            legal_held    <= dec_legal;
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            // Illegal instructions keep zero operands even while stalled.
            if (stall && legal_held && wb_hit) begin
                if (bus.wb_rd == rs1_held)
                    bus.operand_1 <= bus.wb_data;
                if (r_type_held && (bus.wb_rd == rs2_held))
                    bus.operand_2 <= bus.wb_data;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by a random stream,
// checked against an architectural model (register array plus a queue of
// accepted-but-unconsumed instruction words).
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mregs [32];
    logic [31:0] held_q [$];
    logic [31:0] issued [$];
    logic [31:0] consumed [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Expected visible output: decode of the held word against current registers.
    task automatic check_outputs();
        logic [31:0] w;
        logic [6:0]  opc;
        logic        is_r, is_i;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, held_q.size() != 0});
        if (held_q.size() != 0) begin
            w    = held_q[0];
            opc  = w[6:0];
            is_r = (opc == 7'h33);
            is_i = (opc == 7'h13);
            chk("operand_1", bus.operand_1, (is_r || is_i) ? mregs[w[19:15]] : 32'd0);
            chk("operand_2", bus.operand_2, is_r ? mregs[w[24:20]] : 32'd0);
            chk("opcode",    {25'd0, bus.opcode_t2}, {25'd0, opc});
            chk("immediate", {20'd0, bus.immediate}, is_i ? {20'd0, w[31:20]} : 32'd0);
            chk("function3", {29'd0, bus.function3}, {29'd0, w[14:12]});
            chk("function7", {25'd0, bus.function7}, {25'd0, w[31:25]});
            chk("rd",        {27'd0, bus.rd}, {27'd0, w[11:7]});
            chk("illegal",   {31'd0, bus.illegal}, {31'd0, !(is_r || is_i)});
        end
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd, input logic ordy);
        logic rdy_want;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.wb_en     = we;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
        bus.out_ready = ordy;
        rdy_want = (held_q.size() == 0) || ordy;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy_want});
        @(posedge clk);
        if (held_q.size() != 0 && ordy)
            consumed.push_back(held_q.pop_front());
        if (iv && rdy_want) begin
            held_q.push_back(ins);
            issued.push_back(ins);
        end
        if (we && wr != 5'd0)
            mregs[wr] = wd;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic fill_regs();
        for (int i = 1; i < 32; i++)
            cyc(1'b0, 32'd0, 1'b1, 5'(i), $urandom, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w = $urandom;
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        sel = $urandom_range(0, 9);
        if (sel < 4)      w[6:0] = 7'h33;
        else if (sel < 8) w[6:0] = 7'h13;
        else if (sel < 9) w[6:0] = 7'h03;
        return w;
    endfunction

    initial begin
        int n_cons;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b0;
        mregs[0] = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("reset_operand_1", bus.operand_1, 32'd0);
        chk("reset_operand_2", bus.operand_2, 32'd0);
        chk("reset_fields", {bus.immediate, bus.opcode_t2, bus.function3, bus.function7, bus.rd, bus.illegal},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_regs();

        // ADD x3,x1,x2 with x1=5, x2=-3
        cyc(1'b0, 32'd0, 1'b1, 5'd1, 32'h0000_0005, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 5'd2, 32'hFFFF_FFFD, 1'b1);
        cyc(1'b1, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("add_op1", bus.operand_1, 32'd5);
        chk("add_op2", bus.operand_2, 32'hFFFF_FFFD);
        chk("add_rd", {27'd0, bus.rd}, 32'd3);

        // SRAI x4,x2,3 accepted in the same cycle ADD is consumed
        cyc(1'b1, 32'h40315213, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("srai_imm", {20'd0, bus.immediate}, 32'h403);
        chk("srai_f7", {25'd0, bus.function7}, 32'h20);
        chk("srai_op1", bus.operand_1, 32'hFFFF_FFFD);
        chk("srai_op2", bus.operand_2, 32'd0);

        // ADDI x5,x1,1 with a same-cycle write to x1
        cyc(1'b1, 32'h00108293, 1'b1, 5'd1, 32'h0000_1234, 1'b1);
        chk("bypass_op1", bus.operand_1, 32'h0000_1234);

        // Stall with ADD held, then write x2=7
        cyc(1'b1, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 5'd2, 32'd7, 1'b0);
        chk("refresh_op2", bus.operand_2, 32'd7);
        chk("refresh_valid", {31'd0, bus.out_valid}, 32'd1);
        cyc(1'b1, 32'h00108293, 1'b0, 5'd0, 32'd0, 1'b0);
        n_cons = consumed.size();
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("release_one", consumed.size() - n_cons, 32'd1);
        chk("release_valid", {31'd0, bus.out_valid}, 32'd0);

        // Load opcode is illegal; x0 write is ignored
        cyc(1'b1, 32'h0000A183, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("illegal_flag", {31'd0, bus.illegal}, 32'd1);
        chk("illegal_op1", bus.operand_1, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        cyc(1'b1, 32'h000001B3, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("x0_op1", bus.operand_1, 32'd0);
        chk("x0_op2", bus.operand_2, 32'd0);

        // Random stream with random ready and write-backs
        issued.delete();
        consumed.delete();
        held_q.delete();
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), rand_instr(), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("stream_count", consumed.size(), issued.size());
        for (int i = 0; i < issued.size() && i < consumed.size(); i++)
            chk("stream_order", consumed[i], issued[i]);

        // Asynchronous reset while stalled
        cyc(1'b1, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        held_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fill_regs();
        cyc(1'b1, 32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the whole run in case the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
